instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 1024, meaning the instruction memory size in 32-bit words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: stall  input  1  hazard unit hold request; freezes PC and IF/ID.
REQ-007 Port: branch_taken  input  1  redirect request from the branch resolution stage.
REQ-008 Port: branch_target  input  32  byte address of the redirect.
REQ-009 Port: imem_pc  output  32  fetch byte address to instruction memory.
REQ-010 Port: imem_rdata  input  32  instruction word returned combinationally for imem_pc.
REQ-011 Port: ifid_instr  output  32  registered instruction to decode.
REQ-012 Port: ifid_pc_plus4  output  32  registered address of the fetched instruction + 4.
REQ-013 Port: ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 Port: fetch_fault  output  1  sticky flag for an out-of-range or misaligned fetch.
REQ-015 Port: fetch_state  output  2  current FSM state: BOOT=0, RUN=1, HALT=2.

Function
REQ-016 imem_pc SHALL equal the internal PC register with no added logic, so the instruction returns in the same cycle.
REQ-017 FSM: BOOT lasts exactly one cycle after reset release and holds PC; IF/ID stays a bubble; then RUN.
REQ-018 In RUN, at each edge, the highest-priority applicable action SHALL occur: (1) fault, (2) branch_taken, (3) stall, (4) normal fetch.
REQ-019 Normal fetch SHALL perform: ifid_instr<=imem_rdata, ifid_pc_plus4<=PC+4, ifid_valid<=1, PC<=PC+4.
REQ-020 Branch SHALL perform: PC<=branch_target; IF/ID<=bubble (instr 0, pc_plus4 0, valid 0), regardless of stall.
REQ-021 Stall without branch SHALL hold PC and all IF/ID outputs unchanged.
REQ-022 A fault SHALL be detected when branch_taken=1 and branch_target[1:0]!=0, or when in RUN (PC>>2)>=IMEM_DEPTH.
REQ-023 On a fault: fetch_fault<=1; IF/ID<=bubble; PC holds its current value (the bad target is not loaded); state<=HALT.
REQ-024 HALT SHALL hold PC, keep ifid_valid=0, ignore stall and branch_taken, and exit only through reset.
REQ-025 PC+4 SHALL be 32-bit unsigned modulo 2^32; the range check of REQ-022 catches overflow before any wrap is used.
REQ-026 A bubble SHALL never carry imem_rdata; instr 0 decodes as a NOP.

Reset
REQ-027 While reset_n=0, the block SHALL hold: PC=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, fetch_fault=0, state=BOOT.
REQ-028 Reset asserted mid-operation, including in HALT, SHALL apply REQ-027 immediately, without waiting for a clock edge.

Verification
REQ-029 Reset release with memory words 0..2 = 0x01095020, 0xAC0A0000, 0x01495822 -> one BOOT cycle, then on successive edges ifid_instr = those words, pc_plus4 = 4, 8, 12, valid=1.
REQ-030 stall=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID stays {0xAC0A0000, 8, 1}; after release the next edge loads {0x01495822, 12}.
REQ-031 branch_taken=1 with target 0x8 and stall=1 in the same cycle at PC=24 -> PC=8, ifid_valid=0; the next edge loads word 2 with pc_plus4=12.
REQ-032 branch_taken=1 with target 0x6 -> fetch_fault=1, state=HALT, PC unchanged, valid=0; further branches and stalls are ignored until reset.
REQ-033 With IMEM_DEPTH=8 and sequential run -> the edge with PC=32 gives fault and HALT, and the last valid ifid_pc_plus4 is 32.
REQ-034 reset_n driven low asynchronously between edges while in RUN with valid=1 -> all outputs match REQ-027 before the next edge, and BOOT repeats.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, presents it to instruction memory,
// and registers the returned word into the IF/ID pipeline register.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   stall               hazard-unit hold; freezes PC and IF/ID
//   branch_taken        redirect request from branch resolution
//   branch_target[31:0] byte address of the redirect
//   imem_pc[31:0]       fetch byte address (the PC register itself)
//   imem_rdata[31:0]    instruction word for imem_pc, same cycle
//   ifid_instr[31:0]    registered instruction to decode
//   ifid_pc_plus4[31:0] registered fetch address + 4
//   ifid_valid          IF/ID holds a real instruction (0 = bubble)
//   fetch_fault         sticky misaligned / out-of-range fetch flag
//   fetch_state[1:0]    BOOT=0, RUN=1, HALT=2
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [1:0]  fetch_state
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SW   = 2;

  localparam logic [SW-1:0] ST_BOOT = 2'd0;
  localparam logic [SW-1:0] ST_RUN  = 2'd1;
  localparam logic [SW-1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] DEPTH_WORDS = XLEN'(IMEM_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);

  logic [SW-1:0]   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] pc_plus4_c;
  logic            misaligned_c;
  logic            out_of_range_c;

  // Address arithmetic and fault detection for the current PC / redirect.
  // The range check looks at the PC actually being fetched, so a PC that
  // wrapped through 2^32 is never presented as a valid fetch.
  assign pc_plus4_c     = pc_q + PC_STEP;
  assign misaligned_c   = branch_taken && (branch_target[1:0] != 2'b00);
  assign out_of_range_c = (pc_q >> 2) >= DEPTH_WORDS;

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: fault > branch > stall > sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;

    case (state_q)
      ST_BOOT: begin
        // One settling cycle: PC held, IF/ID stays a bubble.
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (misaligned_c || out_of_range_c) begin
          // Bad target is not loaded; PC keeps the last good value.
          fault_d = 1'b1;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (branch_taken) begin
          // Redirect wins over stall; the wrong-path word is squashed.
          pc_d    = branch_target;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4_c;
          valid_d = 1'b1;
          pc_d    = pc_plus4_c;
        end
      end

      ST_HALT: begin
        // Terminal until reset; stall and branch are ignored.
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_pc       = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc4_q;
  assign ifid_valid    = valid_q;
  assign fetch_fault   = fault_q;
  assign fetch_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage with an 8-word memory model.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_pc;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [1:0]  fetch_state;

  int tests;
  int fails;

  logic [31:0] mem [8];

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_pc      (imem_pc),
    .imem_rdata   (imem_rdata),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .fetch_fault  (fetch_fault),
    .fetch_state  (fetch_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return a marker.
  always_comb begin
    if (imem_pc[31:5] == 27'd0) imem_rdata = mem[imem_pc[4:2]];
    else                        imem_rdata = 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    #12;
    tests++; if (imem_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp %h", imem_pc, 32'h0); end
    tests++; if (ifid_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp %h", ifid_instr, 32'h0); end
    tests++; if (ifid_pc_plus4 !== 32'h0) begin fails++; $display("FAIL rst_pc4 got %h exp %h", ifid_pc_plus4, 32'h0); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_fault got %b exp 0", fetch_fault); end
    tests++; if (fetch_state !== 2'd0) begin fails++; $display("FAIL rst_state got %0d exp 0", fetch_state); end
    reset_n = 1'b1;
    step();
    tests++; if (fetch_state !== 2'd1) begin fails++; $display("FAIL boot_state got %0d exp 1", fetch_state); end
    tests++; if (imem_pc !== 32'h0) begin fails++; $display("FAIL boot_pc got %h exp %h", imem_pc, 32'h0); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %b exp 0", ifid_valid); end
    step();
    tests++; if (ifid_instr !== 32'h0109_5020) begin fails++; $display("FAIL seq0_instr got %h exp %h", ifid_instr, 32'h0109_5020); end
    tests++; if (ifid_pc_plus4 !== 32'd4) begin fails++; $display("FAIL seq0_pc4 got %h exp %h", ifid_pc_plus4, 32'd4); end
    tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL seq0_valid got %b exp 1", ifid_valid); end
    step();
    tests++; if (ifid_instr !== 32'hAC0A_0000) begin fails++; $display("FAIL seq1_instr got %h exp %h", ifid_instr, 32'hAC0A_0000); end
    tests++; if (ifid_pc_plus4 !== 32'd8) begin fails++; $display("FAIL seq1_pc4 got %h exp %h", ifid_pc_plus4, 32'd8); end
    tests++; if (imem_pc !== 32'd8) begin fails++; $display("FAIL seq1_pc got %h exp %h", imem_pc, 32'd8); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (imem_pc !== 32'd8) begin fails++; $display("FAIL stall_pc[%0d] got %h exp %h", i, imem_pc, 32'd8); end
      tests++; if (ifid_instr !== 32'hAC0A_0000) begin fails++; $display("FAIL stall_instr[%0d] got %h exp %h", i, ifid_instr, 32'hAC0A_0000); end
      tests++; if (ifid_pc_plus4 !== 32'd8) begin fails++; $display("FAIL stall_pc4[%0d] got %h exp %h", i, ifid_pc_plus4, 32'd8); end
      tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b exp 1", i, ifid_valid); end
    end
    stall = 1'b0;
    step();
    tests++; if (ifid_instr !== 32'h0149_5822) begin fails++; $display("FAIL unstall_instr got %h exp %h", ifid_instr, 32'h0149_5822); end
    tests++; if (ifid_pc_plus4 !== 32'd12) begin fails++; $display("FAIL unstall_pc4 got %h exp %h", ifid_pc_plus4, 32'd12); end
    tests++; if (imem_pc !== 32'd12) begin fails++; $display("FAIL unstall_pc got %h exp %h", imem_pc, 32'd12); end
  endtask

  task automatic test_branch_stall();
    for (int k = 3; k < 6; k++) begin
      step();
      tests++; if (ifid_pc_plus4 !== 32'(4 * (k + 1))) begin fails++; $display("FAIL pre_br_pc4[%0d] got %h exp %h", k, ifid_pc_plus4, 32'(4 * (k + 1))); end
    end
    tests++; if (imem_pc !== 32'd24) begin fails++; $display("FAIL pre_br_pc got %h exp %h", imem_pc, 32'd24); end
    branch_taken = 1'b1; branch_target = 32'h8; stall = 1'b1;
    step();
    tests++; if (imem_pc !== 32'd8) begin fails++; $display("FAIL br_pc got %h exp %h", imem_pc, 32'd8); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL br_valid got %b exp 0", ifid_valid); end
    tests++; if (ifid_instr !== 32'h0) begin fails++; $display("FAIL br_instr got %h exp %h", ifid_instr, 32'h0); end
    tests++; if (ifid_pc_plus4 !== 32'h0) begin fails++; $display("FAIL br_pc4 got %h exp %h", ifid_pc_plus4, 32'h0); end
    branch_taken = 1'b0; stall = 1'b0;
    step();
    tests++; if (ifid_instr !== 32'h0149_5822) begin fails++; $display("FAIL post_br_instr got %h exp %h", ifid_instr, 32'h0149_5822); end
    tests++; if (ifid_pc_plus4 !== 32'd12) begin fails++; $display("FAIL post_br_pc4 got %h exp %h", ifid_pc_plus4, 32'd12); end
    tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL post_br_valid got %b exp 1", ifid_valid); end
  endtask

  task automatic test_range_fault();
    for (int k = 3; k < 8; k++) begin
      step();
      tests++; if (ifid_instr !== mem[k]) begin fails++; $display("FAIL run_instr[%0d] got %h exp %h", k, ifid_instr, mem[k]); end
      tests++; if (ifid_pc_plus4 !== 32'(4 * (k + 1))) begin fails++; $display("FAIL run_pc4[%0d] got %h exp %h", k, ifid_pc_plus4, 32'(4 * (k + 1))); end
    end
    tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL pre_range_fault got %b exp 0", fetch_fault); end
    step();
    tests++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL range_fault got %b exp 1", fetch_fault); end
    tests++; if (fetch_state !== 2'd2) begin fails++; $display("FAIL range_state got %0d exp 2", fetch_state); end
    tests++; if (imem_pc !== 32'd32) begin fails++; $display("FAIL range_pc got %h exp %h", imem_pc, 32'd32); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL range_valid got %b exp 0", ifid_valid); end
    tests++; if (ifid_instr !== 32'h0) begin fails++; $display("FAIL range_instr got %h exp %h", ifid_instr, 32'h0); end
    branch_taken = 1'b1; branch_target = 32'h0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (imem_pc !== 32'd32) begin fails++; $display("FAIL halt_pc[%0d] got %h exp %h", i, imem_pc, 32'd32); end
      tests++; if (fetch_state !== 2'd2) begin fails++; $display("FAIL halt_state[%0d] got %0d exp 2", i, fetch_state); end
      tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL halt_valid[%0d] got %b exp 0", i, ifid_valid); end
    end
    branch_taken = 1'b0; stall = 1'b0;
  endtask

  task automatic test_halt_reset();
    #3 reset_n = 1'b0;
    #1;
    tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL halt_rst_fault got %b exp 0", fetch_fault); end
    tests++; if (fetch_state !== 2'd0) begin fails++; $display("FAIL halt_rst_state got %0d exp 0", fetch_state); end
    tests++; if (imem_pc !== 32'h0) begin fails++; $display("FAIL halt_rst_pc got %h exp %h", imem_pc, 32'h0); end
    step();
    reset_n = 1'b1;
    step();
    tests++; if (fetch_state !== 2'd1) begin fails++; $display("FAIL reboot_state got %0d exp 1", fetch_state); end
    step();
    tests++; if (ifid_instr !== 32'h0109_5020) begin fails++; $display("FAIL reboot_instr got %h exp %h", ifid_instr, 32'h0109_5020); end
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1; branch_target = 32'h6;
    step();
    tests++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL mis_fault got %b exp 1", fetch_fault); end
    tests++; if (fetch_state !== 2'd2) begin fails++; $display("FAIL mis_state got %0d exp 2", fetch_state); end
    tests++; if (imem_pc !== 32'd4) begin fails++; $display("FAIL mis_pc got %h exp %h", imem_pc, 32'd4); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL mis_valid got %b exp 0", ifid_valid); end
    branch_target = 32'h8;
    step();
    tests++; if (imem_pc !== 32'd4) begin fails++; $display("FAIL mis_ign_br_pc got %h exp %h", imem_pc, 32'd4); end
    branch_taken = 1'b0; stall = 1'b1;
    step();
    tests++; if (fetch_state !== 2'd2) begin fails++; $display("FAIL mis_ign_st_state got %0d exp 2", fetch_state); end
    tests++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL mis_sticky got %b exp 1", fetch_fault); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset_run();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid got %b exp 1", ifid_valid); end
    #3 reset_n = 1'b0;
    #1;
    tests++; if (imem_pc !== 32'h0) begin fails++; $display("FAIL ar_pc got %h exp %h", imem_pc, 32'h0); end
    tests++; if (ifid_instr !== 32'h0) begin fails++; $display("FAIL ar_instr got %h exp %h", ifid_instr, 32'h0); end
    tests++; if (ifid_pc_plus4 !== 32'h0) begin fails++; $display("FAIL ar_pc4 got %h exp %h", ifid_pc_plus4, 32'h0); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b exp 0", ifid_valid); end
    tests++; if (fetch_state !== 2'd0) begin fails++; $display("FAIL ar_state got %0d exp 0", fetch_state); end
    step();
    reset_n = 1'b1;
    step();
    tests++; if (fetch_state !== 2'd1) begin fails++; $display("FAIL ar_boot_state got %0d exp 1", fetch_state); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL ar_boot_valid got %b exp 0", ifid_valid); end
    step();
    tests++; if (ifid_pc_plus4 !== 32'd4) begin fails++; $display("FAIL ar_run_pc4 got %h exp %h", ifid_pc_plus4, 32'd4); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mem[0] = 32'h0109_5020;
    mem[1] = 32'hAC0A_0000;
    mem[2] = 32'h0149_5822;
    mem[3] = 32'h3333_3333;
    mem[4] = 32'h4444_4444;
    mem[5] = 32'h5555_5555;
    mem[6] = 32'h6666_6666;
    mem[7] = 32'h7777_7777;
    test_reset();
    test_stall();
    test_branch_stall();
    test_range_fault();
    test_halt_reset();
    test_misaligned();
    test_async_reset_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
